// File: rtl/rx_huge_page_sched.sv
// rx_huge_page_sched: hands out write space in two alternating RX huge pages, then closes and frees each page
module rx_huge_page_sched #(
   parameter int PAGE_SIZE_LOG2 = 21,
   parameter int HDR_BYTES      = 128,
   parameter int IDLE_TIMEOUT   = 1024
) (
   input  logic        trn_clk,
   input  logic        reset,
   input  logic [63:0] huge_page_addr_1,
   input  logic [63:0] huge_page_addr_2,
   input  logic        huge_page_status_1,
   input  logic        huge_page_status_2,
   output logic        huge_page_free_1,
   output logic        huge_page_free_2,
   input  logic        alloc_req,
   input  logic [13:0] alloc_len,
   output logic        alloc_gnt,
   output logic [63:0] alloc_addr,
   input  logic        wr_done,
   output logic        close_req,
   output logic [63:0] close_addr,
   output logic [31:0] close_bytes,
   input  logic        close_ack,
   output logic        cur_page
);
   localparam int OW = PAGE_SIZE_LOG2 + 1;
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [31:0] PAGE_BYTES = 32'(1) << PAGE_SIZE_LOG2;
   typedef enum logic [2:0] {WAIT, ACTIVE, DRAIN, CLOSE, FREE} state_t;
   state_t state;
   logic [OW-1:0] offset;
   logic [7:0] outstanding;
   logic [IW-1:0] idle;
   logic [63:0] base;
   logic [31:0] next_off;
   logic req_pend, fits, grant, dec;
   always_comb begin
      base     = cur_page ? huge_page_addr_2 : huge_page_addr_1;
      next_off = 32'(offset) + 32'(alloc_len);
      req_pend = alloc_req && !alloc_gnt;
      fits     = next_off <= PAGE_BYTES;
      grant    = state == ACTIVE && req_pend && fits && outstanding != 8'hff;
      dec      = wr_done && outstanding != 8'd0;
   end
   always_ff @(posedge trn_clk) begin
      if (reset) begin
         state            <= WAIT;
         cur_page         <= 1'b0;
         offset           <= OW'(HDR_BYTES);
         outstanding      <= 8'd0;
         idle             <= '0;
         alloc_gnt        <= 1'b0;
         alloc_addr       <= 64'd0;
         close_req        <= 1'b0;
         close_addr       <= 64'd0;
         close_bytes      <= 32'd0;
         huge_page_free_1 <= 1'b0;
         huge_page_free_2 <= 1'b0;
      end else begin
         alloc_gnt        <= grant;
         huge_page_free_1 <= 1'b0;
         huge_page_free_2 <= 1'b0;
         outstanding      <= outstanding + 8'(grant) - 8'(dec);
         if (grant) begin
            alloc_addr <= base + 64'(offset);
            offset     <= OW'(next_off);
         end
         case (state)
            WAIT: if (cur_page ? huge_page_status_2 : huge_page_status_1) begin
               state  <= ACTIVE;
               offset <= OW'(HDR_BYTES);
               idle   <= '0;
            end
            ACTIVE: if (grant) idle <= '0;
            else begin
               if (idle != IW'(IDLE_TIMEOUT)) idle <= idle + 1'b1;
               // an oversized request stays pending and is served from the next page
               if (req_pend && !fits) state <= DRAIN;
               else if (idle == IW'(IDLE_TIMEOUT) && offset > OW'(HDR_BYTES)) state <= DRAIN;
            end
            DRAIN: if (outstanding == 8'd0) begin
               state       <= CLOSE;
               close_req   <= 1'b1;
               close_addr  <= base;
               close_bytes <= 32'(offset) - 32'(HDR_BYTES);
            end
            CLOSE: if (close_ack) begin
               state            <= FREE;
               close_req        <= 1'b0;
               huge_page_free_1 <= !cur_page;
               huge_page_free_2 <= cur_page;
            end
            FREE: begin
               state    <= WAIT;
               cur_page <= !cur_page;
            end
            default: state <= WAIT;
         endcase
      end
   end
endmodule

// File: tb/tb_rx_huge_page_sched.sv
// tb_rx_huge_page_sched: directed scenarios for page allocation, closing, draining and switching
module tb_rx_huge_page_sched;
   localparam int T = 1024;
   logic        trn_clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] huge_page_addr_1 = 64'h1_0000_0000;
   logic [63:0] huge_page_addr_2 = 64'h0;
   logic        huge_page_status_1 = 1'b0;
   logic        huge_page_status_2 = 1'b0;
   logic        huge_page_free_1, huge_page_free_2;
   logic        alloc_req = 1'b0;
   logic [13:0] alloc_len = 14'd0;
   logic        alloc_gnt;
   logic [63:0] alloc_addr;
   logic        wr_done = 1'b0;
   logic        close_req;
   logic [63:0] close_addr;
   logic [31:0] close_bytes;
   logic        close_ack = 1'b0;
   logic        cur_page;
   int checks = 0;
   int errors = 0;

   rx_huge_page_sched #(.PAGE_SIZE_LOG2(12), .HDR_BYTES(128), .IDLE_TIMEOUT(T)) dut (
      .trn_clk(trn_clk), .reset(reset),
      .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
      .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
      .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
      .alloc_req(alloc_req), .alloc_len(alloc_len), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
      .wr_done(wr_done), .close_req(close_req), .close_addr(close_addr), .close_bytes(close_bytes),
      .close_ack(close_ack), .cur_page(cur_page)
   );

   always #5 trn_clk = ~trn_clk;

   task tick;
      @(posedge trn_clk);
      #1;
   endtask

   task do_reset;
      reset = 1'b1;
      alloc_req = 1'b0;
      wr_done = 1'b0;
      close_ack = 1'b0;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task req_grant(input logic [13:0] len, output logic got, output logic [63:0] addr, output int lat);
      alloc_req = 1'b1;
      alloc_len = len;
      got = 1'b0;
      addr = 64'd0;
      lat = 0;
      for (int i = 1; i <= 8 && !got; i++) begin
         tick;
         if (alloc_gnt) begin
            got = 1'b1;
            addr = alloc_addr;
            lat = i;
         end
      end
      alloc_req = 1'b0;
      tick;
   endtask

   task pulse_done(input int n);
      for (int i = 0; i < n; i++) begin
         wr_done = 1'b1;
         tick;
         wr_done = 1'b0;
      end
   endtask

   task wait_close(input int max, output int n);
      n = 0;
      while (!close_req && n < max) begin
         tick;
         n++;
      end
   endtask

   task test_reset;
      huge_page_status_1 = 1'b0;
      do_reset;
      checks++;
      if ({alloc_gnt, alloc_addr, close_req, close_addr, close_bytes, huge_page_free_1, huge_page_free_2, cur_page} !== '0) begin
         errors++;
         $display("FAIL reset_outputs gnt=%b addr=%h creq=%b caddr=%h cbytes=%0d f1=%b f2=%b page=%b, expected all 0",
                  alloc_gnt, alloc_addr, close_req, close_addr, close_bytes, huge_page_free_1, huge_page_free_2, cur_page);
      end
   endtask

   task test_basic;
      logic got;
      logic [63:0] a;
      int lat;
      huge_page_status_1 = 1'b1;
      do_reset;
      tick;
      req_grant(14'd64, got, a, lat);
      checks++;
      if (!(got === 1'b1 && a === 64'h1_0000_0080 && lat == 1)) begin
         errors++;
         $display("FAIL basic_alloc64 got=%b addr=%h lat=%0d, expected 1 100000080 1", got, a, lat);
      end
      req_grant(14'd1520, got, a, lat);
      checks++;
      if (!(got === 1'b1 && a === 64'h1_0000_00C0 && lat == 1)) begin
         errors++;
         $display("FAIL basic_alloc1520 got=%b addr=%h lat=%0d, expected 1 1000000c0 1", got, a, lat);
      end
   endtask

   task test_fill_switch;
      logic got, seen;
      logic [63:0] a;
      logic [63:0] exp_a;
      int lat, n;
      huge_page_status_1 = 1'b1;
      do_reset;
      tick;
      for (int i = 0; i < 3; i++) begin
         exp_a = 64'h1_0000_0080 + 64'(i * 1024);
         req_grant(14'd1024, got, a, lat);
         checks++;
         if (!(got === 1'b1 && a === exp_a)) begin
            errors++;
            $display("FAIL fill_grant%0d got=%b addr=%h, expected 1 %h", i, got, a, exp_a);
         end
      end
      alloc_req = 1'b1;
      alloc_len = 14'd1024;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (alloc_gnt || close_req) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL fill_overflow_held gnt_or_close=%b, expected 0", seen);
      end
      pulse_done(3);
      wait_close(6, n);
      checks++;
      if (!(close_req === 1'b1 && close_bytes === 32'd3072 && close_addr === 64'h1_0000_0000)) begin
         errors++;
         $display("FAIL fill_close creq=%b bytes=%0d addr=%h, expected 1 3072 100000000", close_req, close_bytes, close_addr);
      end
      close_ack = 1'b1;
      tick;
      close_ack = 1'b0;
      checks++;
      if (!(close_req === 1'b0 && huge_page_free_1 === 1'b1 && huge_page_free_2 === 1'b0)) begin
         errors++;
         $display("FAIL fill_free_pulse creq=%b f1=%b f2=%b, expected 0 1 0", close_req, huge_page_free_1, huge_page_free_2);
      end
      tick;
      checks++;
      if (!(huge_page_free_1 === 1'b0 && cur_page === 1'b1)) begin
         errors++;
         $display("FAIL fill_switch f1=%b page=%b, expected 0 1", huge_page_free_1, cur_page);
      end
      huge_page_addr_2 = 64'h2_0000_0000;
      huge_page_status_2 = 1'b1;
      got = 1'b0;
      a = 64'd0;
      for (int i = 0; i < 6 && !got; i++) begin
         tick;
         if (alloc_gnt) begin
            got = 1'b1;
            a = alloc_addr;
         end
      end
      alloc_req = 1'b0;
      checks++;
      if (!(got === 1'b1 && a === 64'h2_0000_0080)) begin
         errors++;
         $display("FAIL fill_page2_grant got=%b addr=%h, expected 1 200000080", got, a);
      end
      tick;
      huge_page_status_2 = 1'b0;
   endtask

   task test_exact_fit;
      logic got, seen;
      logic [63:0] a;
      int lat, n;
      logic [13:0] lens [4] = '{14'd1024, 14'd1024, 14'd1024, 14'd896};
      huge_page_status_1 = 1'b1;
      do_reset;
      tick;
      for (int i = 0; i < 4; i++) req_grant(lens[i], got, a, lat);
      checks++;
      if (!(got === 1'b1 && a === 64'h1_0000_0C80)) begin
         errors++;
         $display("FAIL exact_last_grant got=%b addr=%h, expected 1 100000c80", got, a);
      end
      alloc_req = 1'b1;
      alloc_len = 14'd8;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (alloc_gnt) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL exact_full_no_grant gnt=%b, expected 0", seen);
      end
      pulse_done(4);
      wait_close(6, n);
      alloc_req = 1'b0;
      checks++;
      if (!(close_req === 1'b1 && close_bytes === 32'd3968)) begin
         errors++;
         $display("FAIL exact_close creq=%b bytes=%0d, expected 1 3968", close_req, close_bytes);
      end
   endtask

   task test_idle;
      logic got, seen;
      logic [63:0] a;
      int lat, n;
      huge_page_status_1 = 1'b1;
      do_reset;
      tick;
      req_grant(14'd64, got, a, lat);
      pulse_done(1);
      wait_close(T + 20, n);
      checks++;
      if (!(close_req === 1'b1 && n >= T - 8 && n <= T + 8 && close_bytes === 32'd64)) begin
         errors++;
         $display("FAIL idle_timeout creq=%b cycles=%0d bytes=%0d, expected 1 ~%0d 64", close_req, n, close_bytes, T);
      end
      do_reset;
      seen = 1'b0;
      for (int i = 0; i < 10 * T; i++) begin
         tick;
         if (close_req) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL idle_empty_no_close creq_seen=%b, expected 0", seen);
      end
      req_grant(14'd64, got, a, lat);
      checks++;
      if (!(got === 1'b1 && a === 64'h1_0000_0080)) begin
         errors++;
         $display("FAIL idle_empty_still_active got=%b addr=%h, expected 1 100000080", got, a);
      end
   endtask

   task test_drain;
      logic got, seen;
      logic [63:0] a;
      int lat, n;
      huge_page_status_1 = 1'b1;
      do_reset;
      tick;
      req_grant(14'd64, got, a, lat);
      req_grant(14'd64, got, a, lat);
      alloc_req = 1'b1;
      alloc_len = 14'd3968;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         if (close_req) seen = 1'b1;
      end
      pulse_done(1);
      for (int i = 0; i < 3; i++) begin
         tick;
         if (close_req) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL drain_held creq_seen=%b, expected 0", seen);
      end
      pulse_done(1);
      wait_close(5, n);
      alloc_req = 1'b0;
      checks++;
      if (!(close_req === 1'b1 && close_bytes === 32'd128)) begin
         errors++;
         $display("FAIL drain_close creq=%b bytes=%0d, expected 1 128", close_req, close_bytes);
      end
      do_reset;
      tick;
      req_grant(14'd64, got, a, lat);
      alloc_req = 1'b1;
      alloc_len = 14'd64;
      wr_done = 1'b1;
      tick;
      wr_done = 1'b0;
      alloc_req = 1'b0;
      checks++;
      if (alloc_gnt !== 1'b1) begin
         errors++;
         $display("FAIL drain_coincide_grant gnt=%b, expected 1", alloc_gnt);
      end
      tick;
      alloc_req = 1'b1;
      alloc_len = 14'd3968;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (close_req) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL drain_coincide_held creq_seen=%b, expected 0", seen);
      end
      pulse_done(1);
      wait_close(5, n);
      alloc_req = 1'b0;
      checks++;
      if (!(close_req === 1'b1 && close_bytes === 32'd128)) begin
         errors++;
         $display("FAIL drain_coincide_close creq=%b bytes=%0d, expected 1 128", close_req, close_bytes);
      end
   endtask

   task test_reset_mid_close;
      logic got, seen;
      logic [63:0] a;
      int lat, n;
      huge_page_status_1 = 1'b1;
      do_reset;
      tick;
      req_grant(14'd64, got, a, lat);
      pulse_done(1);
      alloc_req = 1'b1;
      alloc_len = 14'd3968;
      wait_close(8, n);
      alloc_req = 1'b0;
      checks++;
      if (close_req !== 1'b1) begin
         errors++;
         $display("FAIL rst_reach_close creq=%b, expected 1", close_req);
      end
      reset = 1'b1;
      close_ack = 1'b1;
      tick;
      reset = 1'b0;
      close_ack = 1'b0;
      checks++;
      if ({alloc_gnt, alloc_addr, close_req, close_addr, close_bytes, huge_page_free_1, huge_page_free_2, cur_page} !== '0) begin
         errors++;
         $display("FAIL rst_mid_close gnt=%b addr=%h creq=%b caddr=%h cbytes=%0d f1=%b f2=%b page=%b, expected all 0",
                  alloc_gnt, alloc_addr, close_req, close_addr, close_bytes, huge_page_free_1, huge_page_free_2, cur_page);
      end
      huge_page_status_1 = 1'b0;
      huge_page_status_2 = 1'b1;
      alloc_req = 1'b1;
      alloc_len = 14'd64;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (alloc_gnt || huge_page_free_1 || huge_page_free_2 || close_req) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_stays_wait activity=%b, expected 0", seen);
      end
      huge_page_status_1 = 1'b1;
      got = 1'b0;
      a = 64'd0;
      for (int i = 0; i < 4 && !got; i++) begin
         tick;
         if (alloc_gnt) begin
            got = 1'b1;
            a = alloc_addr;
         end
      end
      alloc_req = 1'b0;
      huge_page_status_2 = 1'b0;
      checks++;
      if (!(got === 1'b1 && a === 64'h1_0000_0080)) begin
         errors++;
         $display("FAIL rst_resume_page1 got=%b addr=%h, expected 1 100000080", got, a);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_fill_switch;
      test_exact_fit;
      test_idle;
      test_drain;
      test_reset_mid_close;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
